// File: rtl/bus_pkg.sv
// Shared definitions for the multiplexed address/data bus agents:
// transaction-phase state encoding, field widths and burst-size encoding.
package bus_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BURST_W = 8;
  localparam int unsigned BEATS_W = BURST_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_BEGIN = 3'd2,
    ST_WDATA = 3'd3,
    ST_WEND  = 3'd4,
    ST_RDATA = 3'd5,
    ST_DONE  = 3'd6
  } busState_t;

  // Bus carries the beat count minus one so a full 256-beat burst fits in 8 bits.
  function automatic logic [BURST_W-1:0] encodeBurst(input logic [BEATS_W-1:0] beats);
    logic [BEATS_W-1:0] minusOne;
    minusOne = beats - BEATS_W'(1);
    return minusOne[BURST_W-1:0];
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Response watchdog: load arms a countdown of TIMEOUT_CYCLES cycles, clear
// disarms it, expire is high in the last cycle of an uninterrupted countdown.
module bus_timeout_counter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] remaining;
  logic             armed;

  // Countdown register: clear has priority, load restarts, otherwise tick down to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      remaining <= '0;
      armed     <= 1'b0;
    end else if (clear_i) begin
      remaining <= '0;
      armed     <= 1'b0;
    end else if (load_i) begin
      remaining <= LOAD_VAL;
      armed     <= 1'b1;
    end else if (armed && (remaining != '0)) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

  assign expire_o = armed && (remaining == '0);

endmodule

// File: rtl/bus_master_port.sv
// Bus initiator: turns a command/data stream into arbitrated single or burst
// transactions on the shared multiplexed bus. All bus outputs are zero outside
// the phases this master owns so they can be wire-ORed with other agents.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_BEATS      = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [ADDR_W-1:0]    cmd_addr_i,
  input  logic                 cmd_rnw_i,
  input  logic [BEATS_W-1:0]   cmd_beats_i,
  input  logic [3:0]           cmd_be_i,
  input  logic [31:0]          wdata_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  output logic [31:0]          rdata_o,
  output logic                 rdata_valid_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 request_o,
  input  logic                 grant_i,
  output logic                 beginTransaction_o,
  output logic                 endTransaction_o,
  output logic                 dataValid_o,
  output logic [ADDR_W-1:0]    addressData_o,
  output logic [3:0]           byteEnables_o,
  output logic                 readNotWrite_o,
  output logic [BURST_W-1:0]   burstSize_o,
  input  logic                 beginTransaction_i,
  input  logic                 endTransaction_i,
  input  logic                 dataValid_i,
  input  logic                 busy_i,
  input  logic                 busError_i,
  input  logic [ADDR_W-1:0]    addressData_i
);

  busState_t          state, stateNext;
  logic [ADDR_W-1:0]  addrQ;
  logic               rnwQ;
  logic [BEATS_W-1:0] beatsQ;
  logic [BEATS_W-1:0] remainQ;
  logic [3:0]         beQ;
  logic               errQ;
  logic [31:0]        rdataQ;
  logic               rdataValidQ;

  logic               cmdBad;
  logic               wAccept;
  logic               rBeat;
  logic               beatAccepted;
  logic               tmoExpire;
  logic               timeoutHit;
  logic               abortNow;
  logic [BEATS_W-1:0] rRemainAfter;
  logic               unusedBusIn;

  // Only one master on this bus, so another agent's begin strobe carries no information here.
  assign unusedBusIn = beginTransaction_i;

  assign cmdBad       = (cmd_beats_i == '0) || (32'(cmd_beats_i) > MAX_BEATS);
  assign wAccept      = (state == ST_WDATA) && wdata_valid_i && !busy_i;
  assign rBeat        = (state == ST_RDATA) && dataValid_i && (remainQ != '0);
  assign beatAccepted = wAccept || rBeat;
  // A beat landing in the expiry cycle counts as a response, not a timeout.
  assign timeoutHit   = tmoExpire && !beatAccepted;
  assign abortNow     = busError_i || timeoutHit;
  assign rRemainAfter = remainQ - BEATS_W'(rBeat);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   ((state == ST_BEGIN) || beatAccepted),
    .clear_i  (!((state == ST_BEGIN) || (state == ST_WDATA) || (state == ST_RDATA))),
    .expire_o (tmoExpire)
  );

  // Transaction phase sequencing.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:  if (cmd_valid_i) stateNext = cmdBad ? ST_DONE : ST_REQ;
      ST_REQ:   if (grant_i) stateNext = ST_BEGIN;
      ST_BEGIN: begin
        if (busError_i)  stateNext = ST_DONE;
        else if (rnwQ)   stateNext = ST_RDATA;
        else             stateNext = ST_WDATA;
      end
      // Write aborts still close the transaction with an end strobe.
      ST_WDATA: begin
        if (abortNow)                                  stateNext = ST_WEND;
        else if (wAccept && (remainQ == BEATS_W'(1)))  stateNext = ST_WEND;
      end
      ST_WEND:  stateNext = ST_DONE;
      ST_RDATA: if (abortNow || endTransaction_i) stateNext = ST_DONE;
      ST_DONE:  stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  // Phase register; async reset returns to IDLE so every bus output drops at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= stateNext;
  end

  // Command latch, beat counter and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addrQ   <= '0;
      rnwQ    <= 1'b0;
      beatsQ  <= '0;
      remainQ <= '0;
      beQ     <= '0;
      errQ    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            addrQ   <= cmd_addr_i;
            rnwQ    <= cmd_rnw_i;
            beatsQ  <= cmd_beats_i;
            remainQ <= cmd_beats_i;
            beQ     <= cmd_be_i;
            errQ    <= cmdBad;
          end
        end
        ST_BEGIN: if (busError_i) errQ <= 1'b1;
        ST_WDATA: begin
          if (wAccept)  remainQ <= remainQ - BEATS_W'(1);
          if (abortNow) errQ    <= 1'b1;
        end
        ST_RDATA: begin
          remainQ <= rRemainAfter;
          if (dataValid_i && (remainQ == '0))              errQ <= 1'b1;
          if (abortNow)                                    errQ <= 1'b1;
          if (endTransaction_i && (rRemainAfter != '0))    errQ <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read capture: one-cycle-latency strobe per accepted beat, extras dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdataQ      <= '0;
      rdataValidQ <= 1'b0;
    end else begin
      rdataValidQ <= rBeat;
      if (rBeat) rdataQ <= addressData_i;
    end
  end

  // Bus drive: each field is non-zero only in the phase this master owns.
  always_comb begin
    request_o          = 1'b0;
    beginTransaction_o = 1'b0;
    endTransaction_o   = 1'b0;
    dataValid_o        = 1'b0;
    addressData_o      = '0;
    byteEnables_o      = '0;
    readNotWrite_o     = 1'b0;
    burstSize_o        = '0;
    wdata_ready_o      = 1'b0;
    case (state)
      ST_REQ:   request_o = 1'b1;
      ST_BEGIN: begin
        request_o          = 1'b1;
        beginTransaction_o = 1'b1;
        addressData_o      = addrQ;
        readNotWrite_o     = rnwQ;
        byteEnables_o      = beQ;
        burstSize_o        = encodeBurst(beatsQ);
      end
      ST_WDATA: begin
        request_o = 1'b1;
        if (wdata_valid_i) begin
          dataValid_o   = 1'b1;
          addressData_o = wdata_i;
          wdata_ready_o = !busy_i;
        end
      end
      ST_WEND: begin
        request_o        = 1'b1;
        endTransaction_o = 1'b1;
      end
      ST_RDATA: request_o = 1'b1;
      default: ;
    endcase
  end

  assign cmd_ready_o   = rst_ni && (state == ST_IDLE);
  assign rdata_o       = rdataQ;
  assign rdata_valid_o = rdataValidQ;
  assign done_o        = (state == ST_DONE);
  assign err_o         = (state == ST_DONE) && errQ;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port; the bench plays the bus slave and
// the command/data source by hand.
module tb_bus_master_port;

  logic        clk;
  logic        rstN;
  logic        cmdValid, cmdReady, cmdRnw;
  logic [31:0] cmdAddr;
  logic [8:0]  cmdBeats;
  logic [3:0]  cmdBe;
  logic [31:0] wdata;
  logic        wdataValid, wdataReady;
  logic [31:0] rdata;
  logic        rdataValid, done, err;
  logic        request, grant;
  logic        beginOut, endOut, dvOut;
  logic [31:0] adOut;
  logic [3:0]  beOut;
  logic        rnwOut;
  logic [7:0]  burstOut;
  logic        beginIn, endIn, dvIn, busyIn, busErrIn;
  logic [31:0] adIn;

  int unsigned compared;
  int unsigned mismatched;
  int unsigned k, readyCnt, a2Cnt;
  logic [6:0]  busyPat;

  bus_master_port #(
    .TIMEOUT_CYCLES(16),
    .MAX_BEATS(256)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rstN),
    .cmd_valid_i        (cmdValid),
    .cmd_ready_o        (cmdReady),
    .cmd_addr_i         (cmdAddr),
    .cmd_rnw_i          (cmdRnw),
    .cmd_beats_i        (cmdBeats),
    .cmd_be_i           (cmdBe),
    .wdata_i            (wdata),
    .wdata_valid_i      (wdataValid),
    .wdata_ready_o      (wdataReady),
    .rdata_o            (rdata),
    .rdata_valid_o      (rdataValid),
    .done_o             (done),
    .err_o              (err),
    .request_o          (request),
    .grant_i            (grant),
    .beginTransaction_o (beginOut),
    .endTransaction_o   (endOut),
    .dataValid_o        (dvOut),
    .addressData_o      (adOut),
    .byteEnables_o      (beOut),
    .readNotWrite_o     (rnwOut),
    .burstSize_o        (burstOut),
    .beginTransaction_i (beginIn),
    .endTransaction_i   (endIn),
    .dataValid_i        (dvIn),
    .busy_i             (busyIn),
    .busError_i         (busErrIn),
    .addressData_i      (adIn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command for one cycle and grants the bus the following cycle;
  // returns at the negedge of the BEGIN cycle with inputs settled.
  task automatic startTxn(input logic [31:0] a, input logic rnw, input logic [8:0] n,
                          input logic [3:0] b);
    @(negedge clk);
    cmdValid = 1'b1; cmdAddr = a; cmdRnw = rnw; cmdBeats = n; cmdBe = b;
    @(negedge clk);
    cmdValid = 1'b0; grant = 1'b1;
    @(negedge clk);
    grant = 1'b0;
    #1;
    chk1("begin_pulse", beginOut, 1'b1);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rstN = 1'b0; cmdValid = 1'b0; cmdRnw = 1'b0; cmdAddr = '0; cmdBeats = '0; cmdBe = '0;
    wdata = '0; wdataValid = 1'b0; grant = 1'b0;
    beginIn = 1'b0; endIn = 1'b0; dvIn = 1'b0; busyIn = 1'b0; busErrIn = 1'b0; adIn = '0;
    busyPat = 7'b0011100;

    // reset state
    #2;
    chk1("rst_request", request, 1'b0);
    chk1("rst_cmd_ready", cmdReady, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_addr_data", adOut, 32'h0);
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;
    #1 chk1("ready_after_rst", cmdReady, 1'b1);

    // single write, grant on the third request cycle
    @(negedge clk);
    cmdValid = 1'b1; cmdAddr = 32'h100; cmdRnw = 1'b0; cmdBeats = 9'd1; cmdBe = 4'hF;
    wdata = 32'hDEADBEEF; wdataValid = 1'b1;
    #1 chk1("sw_idle_wready", wdataReady, 1'b0);
    @(negedge clk);
    cmdValid = 1'b0;
    #1 chk1("sw_req1", request, 1'b1);
    chk1("sw_busy_ready", cmdReady, 1'b0);
    @(negedge clk);
    #1 chk1("sw_req2_nobegin", beginOut, 1'b0);
    @(negedge clk);
    grant = 1'b1;
    #1 chk1("sw_req3", request, 1'b1);
    @(negedge clk);
    grant = 1'b0;
    #1 chk1("sw_begin", beginOut, 1'b1);
    chk32("sw_begin_addr", adOut, 32'h100);
    chk32("sw_burst", {24'd0, burstOut}, 32'd0);
    chk32("sw_be", {28'd0, beOut}, 32'hF);
    chk1("sw_rnw", rnwOut, 1'b0);
    @(negedge clk);
    #1 chk1("sw_dv", dvOut, 1'b1);
    chk32("sw_wdata", adOut, 32'hDEADBEEF);
    chk1("sw_wready", wdataReady, 1'b1);
    @(negedge clk);
    wdataValid = 1'b0;
    #1 chk1("sw_end", endOut, 1'b1);
    chk32("sw_end_bus_idle", adOut, 32'h0);
    @(negedge clk);
    #1 chk1("sw_done", done, 1'b1);
    chk1("sw_err", err, 1'b0);
    chk1("sw_done_noreq", request, 1'b0);
    @(negedge clk);
    #1 chk1("sw_done_once", done, 1'b0);
    chk1("sw_ready_again", cmdReady, 1'b1);

    // 8-beat burst read of 0..7, end strobe with the last word
    startTxn(32'h200, 1'b1, 9'd8, 4'hF);
    chk32("br_burst", {24'd0, burstOut}, 32'd7);
    chk1("br_rnw", rnwOut, 1'b1);
    chk32("br_addr", adOut, 32'h200);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      dvIn = 1'b1; adIn = 32'(i); endIn = (i == 7);
      #1;
      chk32("br_bus_released", adOut, 32'h0);
      if (i > 0) begin
        chk1("br_rvalid", rdataValid, 1'b1);
        chk32("br_rdata", rdata, 32'(i - 1));
      end else begin
        chk1("br_rvalid_first", rdataValid, 1'b0);
      end
    end
    @(negedge clk);
    dvIn = 1'b0; endIn = 1'b0; adIn = '0;
    #1 chk1("br_rvalid_last", rdataValid, 1'b1);
    chk32("br_rdata_last", rdata, 32'd7);
    chk1("br_done", done, 1'b1);
    chk1("br_err", err, 1'b0);
    @(negedge clk);

    // 4-beat write with busy held over beat 2 for three cycles
    startTxn(32'h300, 1'b0, 9'd4, 4'h3);
    chk32("wb_burst", {24'd0, burstOut}, 32'd3);
    chk32("wb_be", {28'd0, beOut}, 32'h3);
    k = 0; readyCnt = 0; a2Cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      busyIn = busyPat[c]; wdataValid = 1'b1; wdata = 32'hA0 + k;
      #1;
      chk1("wb_dv", dvOut, 1'b1);
      chk32("wb_word", adOut, 32'hA0 + k);
      chk1("wb_wready", wdataReady, !busyPat[c]);
      if (wdataReady) readyCnt++;
      if (adOut == 32'hA2) a2Cnt++;
      if (!busyPat[c]) k++;
    end
    @(negedge clk);
    wdataValid = 1'b0; busyIn = 1'b0;
    #1 chk1("wb_end", endOut, 1'b1);
    chk32("wb_ready_pulses", readyCnt, 32'd4);
    chk32("wb_a2_cycles", a2Cnt, 32'd4);
    @(negedge clk);
    #1 chk1("wb_done", done, 1'b1);
    chk1("wb_err", err, 1'b0);
    @(negedge clk);

    // read with no responder: 16 silent data cycles, then error completion
    startTxn(32'h90000000, 1'b1, 9'd1, 4'hF);
    chk32("to_addr", adOut, 32'h90000000);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      #1 chk1("to_waiting", done, 1'b0);
    end
    @(negedge clk);
    #1 chk1("to_done", done, 1'b1);
    chk1("to_err", err, 1'b1);
    @(negedge clk);

    // bus error during a write: end strobe, then error completion
    startTxn(32'h400, 1'b0, 9'd2, 4'hF);
    @(negedge clk);
    wdataValid = 1'b1; wdata = 32'h55;
    #1 chk1("be_first_wready", wdataReady, 1'b1);
    @(negedge clk);
    wdataValid = 1'b0; busErrIn = 1'b1;
    #1 chk1("be_bubble", dvOut, 1'b0);
    @(negedge clk);
    busErrIn = 1'b0;
    #1 chk1("be_end", endOut, 1'b1);
    chk1("be_not_done_yet", done, 1'b0);
    @(negedge clk);
    #1 chk1("be_done", done, 1'b1);
    chk1("be_err", err, 1'b1);
    @(negedge clk);

    // short burst: 4 beats requested, slave ends after 2
    startTxn(32'h500, 1'b1, 9'd4, 4'hF);
    @(negedge clk);
    dvIn = 1'b1; adIn = 32'h11;
    @(negedge clk);
    adIn = 32'h22;
    #1 chk1("sb_rv1", rdataValid, 1'b1);
    chk32("sb_rd1", rdata, 32'h11);
    @(negedge clk);
    dvIn = 1'b0; endIn = 1'b1; adIn = '0;
    #1 chk1("sb_rv2", rdataValid, 1'b1);
    chk32("sb_rd2", rdata, 32'h22);
    @(negedge clk);
    endIn = 1'b0;
    #1 chk1("sb_no_rv3", rdataValid, 1'b0);
    chk1("sb_done", done, 1'b1);
    chk1("sb_err", err, 1'b1);
    @(negedge clk);

    // bus error coinciding with the final read word: strobe still emitted
    startTxn(32'h600, 1'b1, 9'd1, 4'hF);
    @(negedge clk);
    dvIn = 1'b1; adIn = 32'h77; busErrIn = 1'b1;
    @(negedge clk);
    dvIn = 1'b0; adIn = '0; busErrIn = 1'b0;
    #1 chk1("ce_rv", rdataValid, 1'b1);
    chk32("ce_rd", rdata, 32'h77);
    chk1("ce_done", done, 1'b1);
    chk1("ce_err", err, 1'b1);
    @(negedge clk);

    // illegal beat counts complete with error and no bus activity
    @(negedge clk);
    cmdValid = 1'b1; cmdRnw = 1'b0; cmdBeats = 9'd0;
    @(negedge clk);
    cmdValid = 1'b0;
    #1 chk1("z_done", done, 1'b1);
    chk1("z_err", err, 1'b1);
    chk1("z_noreq", request, 1'b0);
    @(negedge clk);
    @(negedge clk);
    cmdValid = 1'b1; cmdBeats = 9'd257;
    @(negedge clk);
    cmdValid = 1'b0;
    #1 chk1("big_done", done, 1'b1);
    chk1("big_err", err, 1'b1);
    chk1("big_noreq", request, 1'b0);
    @(negedge clk);

    // asynchronous reset during beat 3 of an 8-beat write
    startTxn(32'h700, 1'b0, 9'd8, 4'hF);
    wdataValid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      wdata = 32'hB0 + 32'(b);
      #1;
      if (b == 2) chk1("rs_beat3_dv", dvOut, 1'b1);
    end
    #2 rstN = 1'b0;
    #1 chk1("rs_request", request, 1'b0);
    chk1("rs_dv", dvOut, 1'b0);
    chk32("rs_addr_data", adOut, 32'h0);
    chk1("rs_wready", wdataReady, 1'b0);
    chk1("rs_done", done, 1'b0);
    @(negedge clk);
    wdataValid = 1'b0;
    #1 rstN = 1'b1;
    #1 chk1("rs_ready_after", cmdReady, 1'b1);
    @(negedge clk);
    #1 chk1("rs_no_done1", done, 1'b0);
    @(negedge clk);
    #1 chk1("rs_no_done2", done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
